// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types used by the L1/L2 width adapter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [255:0] lc3b_d_line;
  typedef logic [10:0]  lc3b_L2_tag;

  typedef enum logic [1:0] {
    IDLE,
    L2_READ,
    L2_WRITE,
    RESP
  } lc3b_l2_adapter_state;

endpackage

// File: rtl/l2_line_buffer.sv
// One-entry 256-bit L2 line buffer with full-line load and 128-bit half write.
module l2_line_buffer
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  lc3b_L2_tag load_tag_i,
  input  lc3b_d_line load_data_i,
  input  logic       wr_half_i,
  input  logic       half_sel_i,
  input  lc3b_line   half_data_i,
  input  lc3b_L2_tag lookup_tag_i,
  output logic       hit_o,
  output lc3b_line   half_out_o,
  output lc3b_d_line data_o
);

  lc3b_d_line data_q;
  lc3b_L2_tag tag_q;
  logic       valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag_i;
      data_q  <= load_data_i;
    end else if (wr_half_i) begin
      if (half_sel_i) data_q[255:128] <= half_data_i;
      else            data_q[127:0]   <= half_data_i;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_tag_i);
  assign half_out_o = half_sel_i ? data_q[255:128] : data_q[127:0];
  assign data_o     = data_q;

endmodule

// File: rtl/l2_line_adapter.sv
// 128-bit L1 pmem responder over a 256-bit L2 port; 16-byte writes are merged
// into full L2 lines and a one-line buffer absorbs same-line re-reads.
module l2_line_adapter
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [15:0]  l2_address,
  output logic         l2_read,
  output logic         l2_write,
  output logic [255:0] l2_wdata,
  input  logic [255:0] l2_rdata,
  input  logic         l2_resp
);

  lc3b_l2_adapter_state state_q, state_d;
  logic [15:4] addr_q, addr_d;
  logic        is_write_q, is_write_d;
  lc3b_line    wdata_q, wdata_d;
  lc3b_line    rdata_q, rdata_d;

  logic       buf_hit, buf_load, buf_wr_half;
  lc3b_line   buf_half;
  lc3b_d_line buf_data, buf_load_data;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^pmem_address[3:0];

  l2_line_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .load_i      (buf_load),
    .load_tag_i  (addr_q[15:5]),
    .load_data_i (buf_load_data),
    .wr_half_i   (buf_wr_half),
    .half_sel_i  (pmem_address[4]),
    .half_data_i (pmem_wdata),
    .lookup_tag_i(pmem_address[15:5]),
    .hit_o       (buf_hit),
    .half_out_o  (buf_half),
    .data_o      (buf_data)
  );

  // A write miss fills the buffer with the L2 line already carrying the new half.
  always_comb begin
    buf_load_data = l2_rdata;
    if (is_write_q) begin
      if (addr_q[4]) buf_load_data[255:128] = wdata_q;
      else           buf_load_data[127:0]   = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_write_d  = is_write_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    buf_load    = 1'b0;
    buf_wr_half = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          addr_d     = pmem_address[15:4];
          is_write_d = pmem_write;
          wdata_d    = pmem_wdata;
          if (pmem_write) begin
            if (buf_hit) begin
              buf_wr_half = 1'b1;
              state_d     = L2_WRITE;
            end else begin
              state_d = L2_READ;
            end
          end else if (buf_hit) begin
            rdata_d = buf_half;
            state_d = RESP;
          end else begin
            state_d = L2_READ;
          end
        end
      end
      L2_READ: begin
        if (l2_resp) begin
          buf_load = 1'b1;
          if (is_write_q) begin
            state_d = L2_WRITE;
          end else begin
            rdata_d = addr_q[4] ? l2_rdata[255:128] : l2_rdata[127:0];
            state_d = RESP;
          end
        end
      end
      L2_WRITE: begin
        if (l2_resp) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == RESP);
  assign l2_read    = (state_q == L2_READ);
  assign l2_write   = (state_q == L2_WRITE);
  assign l2_address = {addr_q[15:5], 5'b0};
  assign l2_wdata   = buf_data;

endmodule

// File: tb/tb_l2_line_adapter.sv
// Directed plus randomized bench for l2_line_adapter with an abstract line/buffer model.
module tb_l2_line_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  l2_address;
  logic         l2_read;
  logic         l2_write;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;

  always #5 clk = ~clk;

  l2_line_adapter dut (
    .clk         (clk),
    .reset       (reset),
    .pmem_address(pmem_address),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .l2_address  (l2_address),
    .l2_read     (l2_read),
    .l2_write    (l2_write),
    .l2_wdata    (l2_wdata),
    .l2_rdata    (l2_rdata),
    .l2_resp     (l2_resp)
  );

  int passed = 0;
  int total  = 0;

  // L2 backing store, and what the adapter's buffer should hold.
  logic [255:0] mem [int unsigned];
  bit           m_valid = 1'b0;
  logic [10:0]  m_tag   = '0;
  logic [255:0] m_line  = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic get_line(input logic [10:0] t, output logic [255:0] l);
    if (!mem.exists(int'(t))) mem[int'(t)] = rand_line();
    l = mem[int'(t)];
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " pmem_resp"}, pmem_resp, 0);
    chk({nm, " l2_read"}, l2_read, 0);
    chk({nm, " l2_write"}, l2_write, 0);
    chk({nm, " pmem_rdata"}, pmem_rdata, 0);
    chk({nm, " l2_address"}, l2_address, 0);
  endtask

  // One L1 transaction; also plays the L2 responder with the given latencies.
  task automatic txn(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] wd,
                     input int lat_r, input int lat_w, input string nm);
    logic [10:0]  t;
    bit           h;
    logic [255:0] line;
    logic [255:0] wseen;
    logic [127:0] exp_rd;
    logic [127:0] got_rd;
    int exp_nr, exp_nw, exp_lat;
    int nr, nw, cyc;
    bit done, addr_ok, both;
    t = a[15:5];
    h = m_valid && (m_tag == t);
    if (h) line = m_line;
    else get_line(t, line);
    if (wr) begin
      if (a[4]) line[255:128] = wd;
      else      line[127:0]   = wd;
    end
    exp_rd  = a[4] ? line[255:128] : line[127:0];
    exp_nr  = h ? 0 : lat_r;
    exp_nw  = wr ? lat_w : 0;
    exp_lat = 1 + exp_nr + exp_nw;
    nr = 0; nw = 0; cyc = 0; done = 0; addr_ok = 1; both = 0;
    wseen = '0; got_rd = '0;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = wd;
    while (!done && cyc < 60) begin
      @(negedge clk);
      l2_resp = 1'b0;
      cyc++;
      if (pmem_resp) begin
        done   = 1;
        got_rd = pmem_rdata;
      end else begin
        if (l2_read && l2_write) both = 1;
        if (l2_read) begin
          nr++;
          if (l2_address !== {t, 5'b0}) addr_ok = 0;
          if (nr == lat_r) begin
            l2_rdata = mem[int'(t)];
            l2_resp  = 1'b1;
          end
        end
        if (l2_write) begin
          nw++;
          if (l2_address !== {t, 5'b0}) addr_ok = 0;
          if (nw == lat_w) begin
            wseen         = l2_wdata;
            mem[int'(t)]  = l2_wdata;
            l2_resp       = 1'b1;
          end
        end
      end
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    chk({nm, " done"}, done, 1);
    chk({nm, " latency"}, cyc, exp_lat);
    chk({nm, " l2_read cycles"}, nr, exp_nr);
    chk({nm, " l2_write cycles"}, nw, exp_nw);
    chk({nm, " l2_address"}, addr_ok, 1);
    chk({nm, " rd/wr overlap"}, both, 0);
    if (wr) chk({nm, " l2_wdata"}, wseen, line);
    else    chk({nm, " pmem_rdata"}, got_rd, exp_rd);
    m_valid = 1'b1;
    m_tag   = t;
    m_line  = line;
    @(negedge clk);
    chk({nm, " resp pulse"}, pmem_resp, 0);
  endtask

  initial begin
    logic [10:0] tags [3];
    logic [10:0] t;
    int          sel;
    reset        = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    l2_rdata     = '0;
    l2_resp      = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    mem[32'h091] = {{4{32'hBBBB_BBBB}}, {4{32'hAAAA_AAAA}}};
    txn(1, 0, 16'h1230, '0, 3, 1, "rd_miss_upper");
    txn(1, 0, 16'h1220, '0, 1, 1, "rd_hit_lower");
    txn(0, 1, 16'h4010, {4{32'hDEAD_BEEF}}, 2, 2, "wr_miss_upper");
    txn(1, 1, 16'h4000, {4{32'h0123_4567}}, 2, 3, "rdwr_hit_lower");

    // Reset in the middle of an L2 read, then a stale l2_resp.
    pmem_read    = 1'b1;
    pmem_address = 16'h1230;
    @(negedge clk);
    chk("midreset l2_read", l2_read, 1);
    reset     = 1'b1;
    pmem_read = 1'b0;
    @(negedge clk);
    reset    = 1'b0;
    l2_rdata = rand_line();
    l2_resp  = 1'b1;
    @(negedge clk);
    l2_resp = 1'b0;
    chk_idle_outputs("midreset");
    @(negedge clk);
    chk_idle_outputs("midreset_late");
    m_valid = 1'b0;
    txn(1, 0, 16'h4000, '0, 2, 1, "rd_after_reset");
    txn(1, 0, 16'h7770, '0, 1, 1, "zero_wait_rd");
    txn(0, 1, 16'h7760, {4{32'hCAFE_F00D}}, 1, 1, "zero_wait_wr_hit");

    tags[0] = 11'h091;
    tags[1] = 11'h200;
    tags[2] = 11'h3A5;
    for (int i = 0; i < 30; i++) begin
      t   = tags[$urandom_range(0, 2)];
      sel = $urandom_range(0, 2);
      txn(sel != 1, sel != 0, {t, 1'($urandom), 4'($urandom)},
          {$urandom, $urandom, $urandom, $urandom},
          $urandom_range(1, 4), $urandom_range(1, 4), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
